// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one main-memory port among
// NUM_REQ cache-side requesters (0 = dcache, 1 = icache, 2.. = spare).
// Request fields are captured into registers at grant, so the memory side
// always sees stable, registered address/data/write-enable.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, the 8-bit
// saturating timeout counter and timeout_o are built. When undefined,
// BUSY/DRAIN wait for mem_ack_i or a kill, and timeout_o is tied low.
module mem_rr_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 239
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        kill_i,
    input  logic [NUM_REQ-1:0]        w_en_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] w_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         r_data_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      timeout_o,
    output logic                      mem_req_o,
    output logic                      mem_w_en_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_w_data_o,
    input  logic                      mem_ack_i,
    input  logic [DATA_W-1:0]         mem_r_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Reject parameter values outside the supported range at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("mem_rr_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mem_rr_arbiter: TIMEOUT_CYC must fit the 8-bit counter");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_ff;
    state_t             state_nxt;
    logic [IDX_W-1:0]   gnt_ff;
    logic [IDX_W-1:0]   gnt_nxt;
    logic [IDX_W-1:0]   gnt_inc;
    logic [IDX_W-1:0]   ptr_ff;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_found;
    logic [NUM_REQ-1:0] eligible;
    logic               kill_gnt;
    logic               latch;
    logic               tmo_hit;

    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wen;
    logic [ADDR_W-1:0]  addr_ff;
    logic [DATA_W-1:0]  wdata_ff;
    logic               wen_ff;

    assign eligible = req_i & ~kill_i;
    assign kill_gnt = kill_i[gnt_ff];
    assign gnt_inc  = (gnt_ff == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_ff + IDX_W'(1);

    // Rotating search: the candidate nearest to ptr_ff wins, so iterate from
    // the far end and let later (closer) hits overwrite earlier ones.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_ff) + i) % NUM_REQ);
            if (eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Mux the selected requester's fields with constant slice bases.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = w_data_i[k*DATA_W +: DATA_W];
                sel_wen   = w_en_i[k];
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_ff;

    // Cycle counter for the current transaction: held at zero while idle,
    // counts through BUSY and DRAIN, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_ff <= 8'd0;
        end else if (state_ff == IDLE) begin
            tmo_ff <= 8'd0;
        end else if (tmo_ff != 8'hFF) begin
            tmo_ff <= tmo_ff + 8'd1;
        end
    end

    assign tmo_hit = (state_ff != IDLE) && (tmo_ff == 8'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    // Control state: FSM, owner index and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_ff <= IDLE;
            gnt_ff   <= '0;
            ptr_ff   <= '0;
        end else begin
            state_ff <= state_nxt;
            gnt_ff   <= gnt_nxt;
            ptr_ff   <= ptr_nxt;
        end
    end

    // Capture the winner's request fields at grant; outputs mask these
    // while idle, so they need no reset.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_ff  <= sel_addr;
            wdata_ff <= sel_wdata;
            wen_ff   <= sel_wen;
        end
    end

    // Next-state logic; kill beats ack, ack beats timeout, and every exit
    // from BUSY/DRAIN advances the pointer past the current owner.
    always_comb begin
        state_nxt = state_ff;
        gnt_nxt   = gnt_ff;
        ptr_nxt   = ptr_ff;
        latch     = 1'b0;
        ack_o     = '0;
        timeout_o = 1'b0;
        case (state_ff)
            IDLE: begin
                if (sel_found) begin
                    latch     = 1'b1;
                    gnt_nxt   = sel_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (kill_gnt) begin
                    if (mem_ack_i) begin
                        state_nxt = IDLE;
                        ptr_nxt   = gnt_inc;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (mem_ack_i) begin
                    ack_o[gnt_ff] = 1'b1;
                    state_nxt     = IDLE;
                    ptr_nxt       = gnt_inc;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_inc;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_inc;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-hot owner indication, zero while idle.
    always_comb begin
        grant_o = '0;
        if (state_ff != IDLE) begin
            grant_o[gnt_ff] = 1'b1;
        end
    end

    assign mem_req_o    = (state_ff != IDLE);
    assign mem_addr_o   = mem_req_o ? addr_ff  : '0;
    assign mem_w_data_o = mem_req_o ? wdata_ff : '0;
    assign mem_w_en_o   = mem_req_o ? wen_ff   : 1'b0;
    assign r_data_o     = (|ack_o) ? mem_r_data_i : '0;

endmodule
